// File: rtl/byte_serializer_fifo.sv
// byte_serializer_fifo: buffers parallel words and shifts them out one bit per clock.
// Latency: a word pushed at edge E0 is loaded at E1; its first bit is valid in the cycle after E1.
// Backpressure: in_ready is low when the FIFO holds FIFO_DEPTH words or reset is high; there is no full pass-through.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_data/in_valid      parallel word offered by the source; held by the source until accepted
//   in_ready              FIFO can take a word this cycle
//   ser_bit/ser_valid     registered serial stream; ser_bit is IDLE_BIT whenever ser_valid is low
//   fifo_level            words currently buffered (excludes the word being shifted)
//   underrun              one-cycle pulse in the first idle cycle after a word when nothing was queued

// sync_fifo: generic single-clock FIFO with occupancy count.
// Latency: a pushed word is visible at head_dat one cycle after the push edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_vld,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop_vld,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_vld, pop_vld})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign level    = cnt;
  assign empty    = (cnt == '0);
endmodule

module byte_serializer_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_BIT   = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          ser_bit,
  output logic                          ser_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(DATA_W);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DATA_W - 1);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t              state;
  logic [DATA_W-1:0]   shift_reg;
  logic [CW-1:0]       bit_cnt;
  logic [DATA_W-1:0]   head_dat;
  logic                fifo_empty;
  logic                push_vld;
  logic                pop_vld;
  logic                last_bit;

  // Bit presented first from a word, and the word with that bit consumed.
  function automatic logic lead_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] consume(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Ready comes from the registered level only, so a same-cycle pop never
  // opens a slot in a full FIFO.
  assign in_ready = !reset && (fifo_level < LEVEL_FULL);
  assign push_vld = in_valid && in_ready;

  // bit_cnt == CNT_LAST means the last bit of the current word is on ser_bit.
  assign last_bit = (bit_cnt == CNT_LAST);

  // A load happens from IDLE, or at the end of a word so the next word
  // follows with no gap.
  assign pop_vld = !reset && !fifo_empty && ((state == ST_IDLE) || last_bit);

  sync_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (push_vld),
    .push_dat (in_data),
    .pop_vld  (pop_vld),
    .head_dat (head_dat),
    .level    (fifo_level),
    .empty    (fifo_empty)
  );

  // The first bit of a word is registered straight from the FIFO head at the
  // load edge; shift_reg keeps the remaining bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      ser_bit   <= IDLE_BIT;
      ser_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (pop_vld) begin
        state     <= ST_SHIFT;
        ser_bit   <= lead_bit(head_dat);
        shift_reg <= consume(head_dat);
        bit_cnt   <= '0;
        ser_valid <= 1'b1;
      end else if (state == ST_SHIFT && !last_bit) begin
        ser_bit   <= lead_bit(shift_reg);
        shift_reg <= consume(shift_reg);
        bit_cnt   <= bit_cnt + 1'b1;
      end else if (state == ST_SHIFT) begin
        // Word finished with nothing queued: the stream breaks here.
        state     <= ST_IDLE;
        ser_bit   <= IDLE_BIT;
        ser_valid <= 1'b0;
        underrun  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_byte_serializer_fifo.sv
module tb_byte_serializer_fifo;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, ser_bit, ser_valid, underrun;
  logic [2:0] fifo_level;

  logic       l_reset = 1'b1;
  logic       l_in_valid = 1'b0;
  logic [7:0] l_in_data = 8'h00;
  logic       l_in_ready, l_ser_bit, l_ser_valid, l_underrun;
  logic [2:0] l_fifo_level;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue of buffered words plus queue of not-yet-shown bits.
  logic [7:0] mq[$];
  logic [7:0] acc_q[$];
  bit         bq[$];
  bit         m_valid = 1'b0;
  bit         m_bit = 1'b0;
  bit         m_und = 1'b0;

  always #5 clk = ~clk;

  byte_serializer_fifo #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ser_bit(ser_bit), .ser_valid(ser_valid), .fifo_level(fifo_level), .underrun(underrun));

  byte_serializer_fifo #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .reset(l_reset), .in_data(l_in_data), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .ser_bit(l_ser_bit), .ser_valid(l_ser_valid), .fifo_level(l_fifo_level), .underrun(l_underrun));

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Advance one clock edge and update the model; returns #1 after the edge.
  task automatic step();
    bit         do_push;
    logic [7:0] w;
    logic [7:0] hw;
    do_push = !reset && in_valid && (mq.size() < DEPTH);
    w = in_data;
    @(posedge clk);
    if (reset) begin
      mq.delete(); bq.delete();
      m_valid = 1'b0; m_bit = 1'b0; m_und = 1'b0;
    end else begin
      if (bq.size() > 0) begin
        m_bit = bq.pop_front(); m_valid = 1'b1; m_und = 1'b0;
      end else if (mq.size() > 0) begin
        hw = mq.pop_front();
        for (int i = 7; i >= 0; i--) bq.push_back(hw[i]);
        m_bit = bq.pop_front(); m_valid = 1'b1; m_und = 1'b0;
      end else begin
        m_und = m_valid; m_valid = 1'b0; m_bit = 1'b0;
      end
      if (do_push) begin
        mq.push_back(w);
        acc_q.push_back(w);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; l_reset = 1'b1; in_valid = 1'b0; l_in_valid = 1'b0;
    step(); step();
    n_vec++; if (ser_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", ser_valid); end
    n_vec++; if (ser_bit !== 1'b0) begin n_err++; $display("FAIL reset_bit got %b exp 0", ser_bit); end
    n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun got %b exp 0", underrun); end
    n_vec++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_during got %b exp 0", in_ready); end
    n_vec++; if (l_ser_valid !== 1'b0) begin n_err++; $display("FAIL reset_lsb_valid got %b exp 0", l_ser_valid); end
    reset = 1'b0; l_reset = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_after got %b exp 1", in_ready); end
  endtask

  task automatic test_single_msb();
    logic [7:0] pat;
    bit ev, eb, eu;
    pat = 8'hB0;
    in_valid = 1'b1; in_data = 8'hB0;
    step();
    in_valid = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      ev = (c >= 2 && c <= 9);
      eb = ev ? pat[9 - c] : 1'b0;
      eu = (c == 10);
      n_vec++; if (ser_valid !== ev) begin n_err++; $display("FAIL single_valid c=%0d got %b exp %b", c, ser_valid, ev); end
      n_vec++; if (ser_bit !== eb) begin n_err++; $display("FAIL single_bit c=%0d got %b exp %b", c, ser_bit, eb); end
      n_vec++; if (underrun !== eu) begin n_err++; $display("FAIL single_underrun c=%0d got %b exp %b", c, underrun, eu); end
      if (c == 1) begin
        n_vec++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL single_level c=1 got %0d exp 1", fifo_level); end
      end
      step();
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] pat;
    bit ev, eb, eu;
    pat = 8'hB0;  // 0x0D sent LSB first gives 1,0,1,1,0,0,0,0
    l_in_valid = 1'b1; l_in_data = 8'h0D;
    step();
    l_in_valid = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      ev = (c >= 2 && c <= 9);
      eb = ev ? pat[9 - c] : 1'b0;
      eu = (c == 10);
      n_vec++; if (l_ser_valid !== ev) begin n_err++; $display("FAIL lsb_valid c=%0d got %b exp %b", c, l_ser_valid, ev); end
      n_vec++; if (l_ser_bit !== eb) begin n_err++; $display("FAIL lsb_bit c=%0d got %b exp %b", c, l_ser_bit, eb); end
      n_vec++; if (l_underrun !== eu) begin n_err++; $display("FAIL lsb_underrun c=%0d got %b exp %b", c, l_underrun, eu); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words[4];
    bit exp_bits[$];
    bit got_bits[$];
    int first_v, last_v, n_und, bad;
    words = '{8'hAA, 8'h55, 8'hF0, 8'h0F};
    foreach (words[i]) for (int b = 7; b >= 0; b--) exp_bits.push_back(words[i][b]);
    first_v = -1; last_v = -1; n_und = 0; bad = 0;
    for (int cyc = 0; cyc < 44; cyc++) begin
      in_valid = (cyc < 4);
      in_data = (cyc < 4) ? words[cyc] : 8'h00;
      step();
      if (ser_valid) begin
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        got_bits.push_back(ser_bit);
      end
      if (underrun) n_und++;
    end
    in_valid = 1'b0;
    n_vec++; if (got_bits.size() != 32) begin n_err++; $display("FAIL b2b_count got %0d exp 32", got_bits.size()); end
    n_vec++; if (last_v - first_v + 1 != 32) begin n_err++; $display("FAIL b2b_span got %0d exp 32", last_v - first_v + 1); end
    for (int i = 0; i < 32 && i < got_bits.size(); i++) if (got_bits[i] != exp_bits[i]) bad++;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL b2b_bits got %0d wrong bits exp 0", bad); end
    n_vec++; if (n_und != 1) begin n_err++; $display("FAIL b2b_underrun got %0d pulses exp 1", n_und); end
    n_vec++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL b2b_level got %0d exp 0", fifo_level); end
  endtask

  task automatic test_full();
    logic [7:0] src;
    bit acc, saw_full, rdy_exp;
    bit got_bits[$];
    int n_acc, bad;
    logic [7:0] w;
    src = 8'h10; saw_full = 1'b0; n_acc = 0; bad = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      in_valid = (cyc < 12);
      in_data = src;
      rdy_exp = (mq.size() < DEPTH);
      n_vec++; if (in_ready !== rdy_exp) begin n_err++; $display("FAIL full_ready cyc=%0d got %b exp %b", cyc, in_ready, rdy_exp); end
      if (!rdy_exp) saw_full = 1'b1;
      acc = in_valid && rdy_exp;
      step();
      if (acc) begin src++; n_acc++; end
      n_vec++; if (fifo_level !== 3'(mq.size())) begin n_err++; $display("FAIL full_level cyc=%0d got %0d exp %0d", cyc, fifo_level, mq.size()); end
      if (ser_valid) got_bits.push_back(ser_bit);
    end
    in_valid = 1'b0;
    n_vec++; if (saw_full !== 1'b1) begin n_err++; $display("FAIL full_backpressure got %b exp 1", saw_full); end
    n_vec++; if (got_bits.size() != n_acc * 8) begin n_err++; $display("FAIL full_bitcount got %0d exp %0d", got_bits.size(), n_acc * 8); end
    for (int k = 0; k < n_acc && (k * 8 + 7) < got_bits.size(); k++) begin
      for (int b = 0; b < 8; b++) w[7 - b] = got_bits[k * 8 + b];
      if (w != 8'(8'h10 + k)) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL full_order got %0d wrong words exp 0", bad); end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] words[3];
    int seen;
    words = '{8'hAA, 8'h55, 8'h33};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = words[i];
      step();
    end
    in_valid = 1'b0;
    step(); step();
    // AA's bit index 3 (bit 4 = 0) is now on the line with two words queued.
    n_vec++; if (ser_valid !== 1'b1 || ser_bit !== 1'b0) begin n_err++; $display("FAIL midrst_pre got v=%b b=%b exp v=1 b=0", ser_valid, ser_bit); end
    n_vec++; if (fifo_level !== 3'd2) begin n_err++; $display("FAIL midrst_prelevel got %0d exp 2", fifo_level); end
    reset = 1'b1;
    step();
    n_vec++; if (ser_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b exp 0", ser_valid); end
    n_vec++; if (ser_bit !== 1'b0) begin n_err++; $display("FAIL midrst_bit got %b exp 0", ser_bit); end
    n_vec++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL midrst_level got %0d exp 0", fifo_level); end
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ser_valid || underrun || fifo_level != 0) seen++;
    end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL midrst_quiet got %0d active cycles exp 0", seen); end
  endtask

  task automatic test_random();
    bit pend, will_acc, rdy_exp;
    int p, dut_und, mdl_und, bad;
    bit got_bits[$];
    bit exp_bits[$];
    acc_q.delete();
    pend = 1'b0; dut_und = 0; mdl_und = 0; bad = 0;
    for (int cyc = 0; cyc < 2100; cyc++) begin
      p = (cyc >= 2000) ? 0 : (((cyc / 200) % 2) != 0 ? 70 : 10);
      if (!pend && $urandom_range(0, 99) < p) begin
        pend = 1'b1; in_data = 8'($urandom);
      end
      in_valid = pend;
      rdy_exp = (mq.size() < DEPTH);
      n_vec++; if (in_ready !== rdy_exp) begin n_err++; if (n_err < 20) $display("FAIL rnd_ready cyc=%0d got %b exp %b", cyc, in_ready, rdy_exp); end
      will_acc = pend && rdy_exp;
      step();
      if (will_acc) pend = 1'b0;
      n_vec++; if (ser_valid !== m_valid) begin n_err++; if (n_err < 20) $display("FAIL rnd_valid cyc=%0d got %b exp %b", cyc, ser_valid, m_valid); end
      n_vec++; if (ser_bit !== m_bit) begin n_err++; if (n_err < 20) $display("FAIL rnd_bit cyc=%0d got %b exp %b", cyc, ser_bit, m_bit); end
      n_vec++; if (underrun !== m_und) begin n_err++; if (n_err < 20) $display("FAIL rnd_underrun cyc=%0d got %b exp %b", cyc, underrun, m_und); end
      n_vec++; if (fifo_level !== 3'(mq.size())) begin n_err++; if (n_err < 20) $display("FAIL rnd_level cyc=%0d got %0d exp %0d", cyc, fifo_level, mq.size()); end
      if (ser_valid) got_bits.push_back(ser_bit);
      if (underrun) dut_und++;
      if (m_und) mdl_und++;
    end
    in_valid = 1'b0;
    foreach (acc_q[i]) for (int b = 7; b >= 0; b--) exp_bits.push_back(acc_q[i][b]);
    n_vec++; if (got_bits.size() != exp_bits.size()) begin n_err++; $display("FAIL rnd_streamlen got %0d exp %0d", got_bits.size(), exp_bits.size()); end
    for (int i = 0; i < got_bits.size() && i < exp_bits.size(); i++) if (got_bits[i] != exp_bits[i]) bad++;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL rnd_stream got %0d wrong bits exp 0", bad); end
    n_vec++; if (dut_und != mdl_und || mdl_und == 0) begin n_err++; $display("FAIL rnd_breaks got %0d underruns exp %0d (nonzero)", dut_und, mdl_und); end
  endtask

  initial begin
    test_reset();
    test_single_msb();
    test_lsb_first();
    test_back_to_back();
    test_full();
    test_reset_mid_word();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/byte_serializer_fifo.md
Name: byte_serializer_fifo

Overview:
Upstream feeder for the bit-serial sequence detector. It accepts parallel words over a valid/ready handshake into a small FIFO, then shifts each word out one bit per clock. ser_bit drives the detector's inp_bit directly. Consecutive buffered words stream with no idle gap; idle cycles output a fixed fill bit.

Parameters:
DATA_W, 8, width of each parallel word (>=2)
FIFO_DEPTH, 4, number of buffered words (power of 2, >=2)
MSB_FIRST, 1, 1 = shift bit DATA_W-1 first; 0 = shift bit 0 first
IDLE_BIT, 0, value driven on ser_bit when no word is being shifted

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_data  input  DATA_W  parallel word to serialize
in_valid  input  1  in_data valid
in_ready  output  1  FIFO can accept a word this cycle
ser_bit  output  1  serial bit stream (to detector inp_bit)
ser_valid  output  1  ser_bit carries a data bit (not idle fill)
fifo_level  output  $clog2(FIFO_DEPTH)+1  words currently in FIFO
underrun  output  1  one-cycle pulse when the stream breaks after a word

Behaviour:
- Reset: already decided — reset reset, synchronous, active-high; clock clk.
- While reset is high, at each edge: FIFO flushed, fifo_level=0, shifter state=IDLE, ser_bit=IDLE_BIT, ser_valid=0, underrun=0.
- in_ready is 0 during reset. Otherwise in_ready = (fifo_level < FIFO_DEPTH), decoded combinationally from registered level.
- Push: in_valid && in_ready at an edge writes in_data to the FIFO tail. in_valid with in_ready=0 is ignored; the source must hold the word.
- Full FIFO: in_ready=0 even if a pop occurs in the same cycle (no pass-through when full).
- Simultaneous push and pop: level unchanged; FIFO order preserved.
- Shifter FSM states: IDLE, SHIFT. Registers: shift_reg[DATA_W], bit_cnt[$clog2(DATA_W)].
- IDLE, FIFO non-empty: pop the head into shift_reg, bit_cnt=0, go to SHIFT. Otherwise remain in IDLE.
- SHIFT: ser_bit is registered. Each cycle, output the next bit (MSB or LSB per MSB_FIRST) and increment bit_cnt.
- End of word (bit_cnt==DATA_W-1), FIFO non-empty: pop and load the next word at the same edge. The first bit of the next word follows the last bit of the current word on the very next cycle (gapless).
- End of word, FIFO empty: go to IDLE. Next cycle ser_valid=0, ser_bit=IDLE_BIT, underrun=1 for exactly one cycle.
- Latency: word pushed at edge E0 → loaded at E1 (if shifter idle) → first bit has ser_valid=1 in the cycle after E1 (two cycles after the push). Last bit appears DATA_W-1 cycles later.
- ser_valid=1 exactly DATA_W consecutive cycles per word. ser_bit=IDLE_BIT whenever ser_valid=0.
- Reset mid-word: the partial word is discarded and buffered words are lost. ser_valid=0 from the cycle after the reset edge.
- fifo_level never exceeds FIFO_DEPTH and never goes below 0. Read/write pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset then single push 0xB0 (MSB_FIRST=1) at cycle 0 → ser_valid high cycles 2–9, ser_bit 1,0,1,1,0,0,0,0; underrun pulse cycle 10; detector seq_seen pulses once after 4th bit.
- Push 0x0D with MSB_FIRST=0 → ser_bit 1,0,1,1,0,0,0,0; behaves identically to the previous case downstream.
- Push 0xAA,0x55,0xF0,0x0F back-to-back → 32 continuous ser_valid cycles, bits in order with no gap; single underrun after the final bit; fifo_level returns to 0.
- Hold in_valid high with incrementing data for 12 cycles → in_ready drops when fifo_level=4, no word lost or duplicated, output order matches push order, fifo_level never >4.
- Assert reset for 1 cycle during bit 3 of a word with 2 words queued → next cycle ser_valid=0, ser_bit=IDLE_BIT, fifo_level=0, no further bits until a new push.
- Random pushes/stalls for 2000 cycles against a scoreboard → serialized stream equals concatenated accepted words; underrun count equals number of stream breaks.
